// File: rtl/state_pkg.sv
// Shared player types and screen geometry for player_ctl_1 and draw_player_1.
package state_pkg;
  typedef enum logic [1:0] {IDLE1 = 2'd0, RIGHT1 = 2'd1, LEFT1 = 2'd2} State1;

  localparam int H_RES     = 1024;
  localparam int SPRITE_W  = 40;
  localparam int X_MIN_DEF = 0;
  localparam int X_MAX_DEF = H_RES - SPRITE_W;
  localparam int XW        = 12;
  localparam int HOLD_SAT  = 16;

  // Signed one-bit-wider arithmetic lets underflow show up as a negative value.
  function automatic logic [XW-1:0] clamp_x(input logic signed [XW:0] v, lo, hi);
    if (v < lo)      return lo[XW-1:0];
    else if (v > hi) return hi[XW-1:0];
    else             return v[XW-1:0];
  endfunction
endpackage

// File: rtl/player_ctl_1_if.sv
// Input front-end / draw_player_1 side of the player 1 movement controller.
interface player_ctl_1_if;
  import state_pkg::*;
  logic          btn_left;
  logic          btn_right;
  logic          vsync_in;
  logic [XW-1:0] xpos_player1;
  State1         state;
  logic          frame_tick;

  modport master (output btn_left, btn_right, vsync_in,
                  input  xpos_player1, state, frame_tick);
  modport slave  (input  btn_left, btn_right, vsync_in,
                  output xpos_player1, state, frame_tick);
endinterface

// File: rtl/player_ctl_1_sync_edge_det.sv
// sync_edge_det: W-bit 2-FF synchronizer with a registered rising-edge pulse per bit.
module sync_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      rise <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

  assign q = s2;
endmodule

// File: rtl/player_ctl_1.sv
// Player 1 movement controller: button requests -> xpos/state, updated once per frame.
// Optional PLAYER1_ACCEL_EN doubles the step after 16 consecutive same-direction ticks.
module player_ctl_1 import state_pkg::*; #(
  parameter int X_INIT      = 500,
  parameter int X_MIN       = X_MIN_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int STEP        = 4,
  parameter int IDLE_FRAMES = 8
) (
  input logic           clk,
  input logic           rst,
  player_ctl_1_if.slave bus
);
  localparam int IW = $clog2(IDLE_FRAMES + 1);

  logic [1:0]    btn_s, btn_edge_unused;
  logic          vs_sync_unused, tick;
  logic          req_r, req_l;
  State1         state_q, state_d;
  logic [XW-1:0] xpos_q, xpos_d;
  logic [IW-1:0] idle_q, idle_d;
  logic signed [XW:0] x_ext, step;

  sync_edge_det #(.W(2)) u_btn (
    .clk(clk), .rst(rst), .d({bus.btn_left, bus.btn_right}),
    .q(btn_s), .rise(btn_edge_unused)
  );

  sync_edge_det #(.W(1)) u_vs (
    .clk(clk), .rst(rst), .d(bus.vsync_in),
    .q(vs_sync_unused), .rise(tick)
  );

  // Both or neither pressed is treated as no request.
  assign req_r = btn_s[0] & ~btn_s[1];
  assign req_l = btn_s[1] & ~btn_s[0];

`ifdef PLAYER1_ACCEL_EN
  logic [4:0] hold_q, hold_d, hold_nx;
  logic       same;

  always_comb begin
    same    = (req_r && state_q == RIGHT1) || (req_l && state_q == LEFT1);
    hold_nx = 5'd1;
    if (same && hold_q != '0)
      hold_nx = (hold_q == 5'(HOLD_SAT)) ? hold_q : hold_q + 5'd1;
    step = (hold_nx == 5'(HOLD_SAT)) ? (XW+1)'(2 * STEP) : (XW+1)'(STEP);
  end
`else
  assign step = (XW+1)'(STEP);
`endif

  assign x_ext = $signed({1'b0, xpos_q});

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    idle_d  = idle_q;
`ifdef PLAYER1_ACCEL_EN
    hold_d  = hold_q;
`endif
    if (tick) begin
      if (req_r || req_l) begin
        state_d = req_r ? RIGHT1 : LEFT1;
        xpos_d  = clamp_x(req_r ? x_ext + step : x_ext - step,
                          (XW+1)'(X_MIN), (XW+1)'(X_MAX));
        idle_d  = '0;
`ifdef PLAYER1_ACCEL_EN
        hold_d  = hold_nx;
`endif
      end else begin
`ifdef PLAYER1_ACCEL_EN
        hold_d = '0;
`endif
        if (state_q != IDLE1) begin
          if (idle_q == IW'(IDLE_FRAMES - 1)) begin
            state_d = IDLE1;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE1;
      xpos_q  <= XW'(X_INIT);
      idle_q  <= '0;
`ifdef PLAYER1_ACCEL_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      idle_q  <= idle_d;
`ifdef PLAYER1_ACCEL_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.xpos_player1 = xpos_q;
  assign bus.state        = state_q;
  assign bus.frame_tick   = tick;
endmodule
